// File: rtl/gblcd_tx.sv
// Game Boy LCD signal transmitter: emits pixclk/hsync/vsync/gb_d with the edge
// conventions the gblcd capture block expects, sourcing pixels from RAM or a test pattern.
module gblcd_tx #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 160,
  parameter int H_TOTAL  = 400,
  parameter int HSYNC_W  = 2,
  parameter int V_ACTIVE = 144,
  parameter int V_TOTAL  = 154
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  output logic       pix_rd,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  input  logic [1:0] pix_in,
  output logic [1:0] gb_d,
  output logic       pixclk,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(H_TOTAL);
  localparam int LW = $clog2(V_TOTAL);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] H_LAST   = SW'(H_TOTAL - 1);
  localparam logic [SW-1:0] H_ACT    = SW'(H_ACTIVE);
  localparam logic [SW-1:0] HS_START = SW'(H_TOTAL - HSYNC_W);
  localparam logic [LW-1:0] V_LAST   = LW'(V_TOTAL - 1);
  localparam logic [LW-1:0] V_ACT    = LW'(V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [DW-1:0] div, n_div;
  logic          half, n_half;
  logic [SW-1:0] slot, n_slot, fx;
  logic [LW-1:0] line_cnt, n_line, fy;
  logic [1:0]    mode_q, pf, pf_d, pat;
  logic [7:0]    fx8, fy8;
  logic          div_end, slot_end, line_end, frame_end, n_active, fv, rd_next;

  always_comb begin
    div_end   = (div == DIV_LAST);
    slot_end  = div_end & half;
    line_end  = slot_end & (slot == H_LAST);
    frame_end = line_end & (line_cnt == V_LAST);
    n_div     = div_end ? '0 : div + DW'(1);
    n_half    = div_end ? ~half : half;
    n_slot    = slot;
    if (slot_end) n_slot = (slot == H_LAST) ? '0 : slot + SW'(1);
    n_line    = line_cnt;
    if (line_end) n_line = (line_cnt == V_LAST) ? '0 : line_cnt + LW'(1);
    n_active  = (n_line < V_ACT) && (n_slot < H_ACT);

    // Coordinates of the pixel shown in the slot after the current one.
    if (slot == H_LAST) begin
      fx = '0;
      fy = (line_cnt == V_LAST) ? '0 : line_cnt + LW'(1);
      fv = (fy < V_ACT);
    end else begin
      fx = slot + SW'(1);
      fy = line_cnt;
      fv = (fx < H_ACT) && (line_cnt < V_ACT);
    end
    fx8 = 8'(fx);
    fy8 = 8'(fy);

    case (mode_q)
      2'd1:    pat = (fx8[3] ^ fy8[3]) ? 2'd3 : 2'd0;
      2'd2:    pat = fx8[5:4];
      2'd3:    pat = fy8[5:4];
      default: pat = 2'd0;
    endcase

    // pix_rd/pix_in is a fixed-latency strobe: no backpressure, data is
    // sampled on the clk after the strobe (div=1 of half B).
    rd_next = (mode_q == 2'd0) && n_half && (n_div == '0) && fv;
    pf_d = pf;
    if (state == RUN && half && div == DW'(1) && fv)
      pf_d = (mode_q == 2'd0) ? pix_in : pat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div         <= '0;
      half        <= 1'b0;
      slot        <= '0;
      line_cnt    <= '0;
      mode_q      <= 2'd0;
      pf          <= 2'd0;
      gb_d        <= 2'd0;
      pixclk      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      pix_rd      <= 1'b0;
      pix_x       <= 8'd0;
      pix_y       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          div         <= '0;
          half        <= 1'b0;
          slot        <= '0;
          line_cnt    <= '0;
          pf          <= 2'd0;
          gb_d        <= 2'd0;
          hsync       <= 1'b0;
          vsync       <= 1'b0;
          pix_rd      <= 1'b0;
          pix_x       <= 8'd0;
          pix_y       <= 8'd0;
          // Pixel (0,0) of the first frame has no prefetch, so it shows as 0.
          pixclk      <= en;
          frame_start <= en;
          if (en) begin
            state  <= RUN;
            mode_q <= mode;
          end
        end
        RUN: begin
          if (frame_end && !en) begin
            state       <= IDLE;
            div         <= '0;
            half        <= 1'b0;
            slot        <= '0;
            line_cnt    <= '0;
            pf          <= 2'd0;
            gb_d        <= 2'd0;
            pixclk      <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
            pix_rd      <= 1'b0;
            pix_x       <= 8'd0;
            pix_y       <= 8'd0;
          end else begin
            div         <= n_div;
            half        <= n_half;
            slot        <= n_slot;
            line_cnt    <= n_line;
            pf          <= pf_d;
            if (frame_end) mode_q <= mode;
            frame_start <= frame_end;
            pixclk      <= n_active & ~n_half;
            if (!n_active) gb_d <= 2'd0;
            else if (!n_half && n_div == '0) gb_d <= pf_d;
            hsync       <= (n_slot >= HS_START);
            vsync       <= (n_line == V_LAST);
            pix_rd      <= rd_next;
            pix_x       <= rd_next ? fx8 : 8'd0;
            pix_y       <= rd_next ? fy8 : 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
